// File: rtl/banner_sequencer.sv
// banner_sequencer: animation controller for a row of letter glyph renderers.
// Produces the banner origin and per-letter enables; the animation slides the
// banner down, reveals letters left to right, blinks them, then holds.
// Every step of the animation is paced by frame_tick.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   frame_tick one-cycle pulse per video frame
//   start      one-cycle request to begin the animation (ignored unless idle)
//   stop       one-cycle request to abort and clear the banner
//   base_x     banner origin x, tied to X_POS
//   base_y     banner origin y
//   letter_en  per-letter enable, bit 0 is the leftmost letter
//   busy       high whenever the animation is not idle
//   done       one-cycle pulse on entry to the hold state
module banner_sequencer #(
    parameter int unsigned NCHAR         = 4,
    parameter int unsigned PITCH         = 40,
    parameter int unsigned X_POS         = 256,
    parameter int unsigned Y_START       = 0,
    parameter int unsigned Y_TARGET      = 220,
    parameter int unsigned STEP          = 4,
    parameter int unsigned REVEAL_FRAMES = 8,
    parameter int unsigned BLINK_FRAMES  = 16,
    parameter int unsigned BLINK_COUNT   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             stop,
    output logic [9:0]       base_x,
    output logic [9:0]       base_y,
    output logic [NCHAR-1:0] letter_en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FrameMax = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES
                                                                      : BLINK_FRAMES;
    localparam int unsigned FW = (FrameMax > 1) ? $clog2(FrameMax) : 1;
    localparam int unsigned BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSlide,
        StReveal,
        StBlink,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       base_y_q, base_y_d;
    logic [NCHAR-1:0] letter_en_q, letter_en_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             done_q, done_d;

    // 11-bit sum so the slide step can never wrap past 1023.
    logic [10:0]      y_sum;
    logic [NCHAR-1:0] en_shift;

    // Letter spacing is applied by the instantiating level, not here.
    logic [31:0] unused_pitch;
    assign unused_pitch = PITCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_y_q    <= 10'(Y_START);
            letter_en_q <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_y_q    <= base_y_d;
            letter_en_q <= letter_en_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_y_d    = base_y_q;
        letter_en_d = letter_en_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        done_d      = 1'b0;
        y_sum       = {1'b0, base_y_q} + 11'(STEP);
        en_shift    = (letter_en_q << 1) | NCHAR'(1);

        if (stop) begin
            state_d     = StIdle;
            base_y_d    = 10'(Y_START);
            letter_en_d = '0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    base_y_d    = 10'(Y_START);
                    letter_en_d = '0;
                    // A frame_tick in the start cycle is deliberately dropped.
                    if (start) begin
                        state_d = StSlide;
                    end
                end
                StSlide: begin
                    letter_en_d = '0;
                    if (frame_tick) begin
                        if (y_sum >= 11'(Y_TARGET)) begin
                            base_y_d    = 10'(Y_TARGET);
                            frame_cnt_d = '0;
                            state_d     = StReveal;
                        end else begin
                            base_y_d = y_sum[9:0];
                        end
                    end
                end
                StReveal: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == FW'(REVEAL_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            letter_en_d = en_shift;
                            if (&en_shift) begin
                                blink_cnt_d = '0;
                                state_d     = StBlink;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end
                end
                StBlink: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            letter_en_d = ~letter_en_q;
                            blink_cnt_d = blink_cnt_q + BW'(1);
                            // Even toggle count always lands back on all ones.
                            if (blink_cnt_q == BW'(BLINK_COUNT - 1)) begin
                                letter_en_d = '1;
                                state_d     = StHold;
                                done_d      = 1'b1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end
                end
                StHold: begin
                    letter_en_d = '1;
                    base_y_d    = 10'(Y_TARGET);
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign base_x    = 10'(X_POS);
    assign base_y    = base_y_q;
    assign letter_en = letter_en_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule
